adder_pipe_seg: RTL and testbench



---
 rtl/adder_pipe_seg.sv | 174 +++++++++++++++++
 tb/tb_adder_pipe_seg.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_seg.sv
// -----------------------------------------------------------------------------
// adder_pipe_seg
//
// Pipelined segmented adder. The W = SEG_W*NSEG bit operands are cut into NSEG
// segments. Stage k adds segment k and passes its carry to stage k+1 through a
// register. Operand segment k is delayed k-1 cycles so it meets its carry at
// stage k. Partial sum k is delayed a further NSEG-k cycles so that all
// segments of one beat land in the output register together. Latency is NSEG
// cycles. Throughput is one beat per cycle.
//
// The whole pipeline advances as one unit whenever the output register is
// empty or is being drained (adv). There is no per-stage elastic buffering:
// bubbles travel through as invalid stages.
//
// Optional feature, enabled by defining ADDER_PIPE_SUB_EN:
//   Adds input port sub. When sub = 1 the beat computes A - B: B is inverted,
//   carry-in is forced to 1 and c0 is ignored. In that case cout = 1 means no
//   borrow occurred.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle (= adv, independent of in_valid)
//   A, B       operands, bit 1 = LSB
//   c0         carry-in
//   sub        subtract select, per beat (only with ADDER_PIPE_SUB_EN)
//   out_valid  result valid
//   out_ready  downstream accepts result
//   S          registered sum
//   cout       registered carry out of bit W
// -----------------------------------------------------------------------------
module adder_pipe_seg #(
    parameter int unsigned  SEG_W = 24,
    parameter int unsigned  NSEG  = 3,
    localparam int unsigned W     = SEG_W * NSEG
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W:1]   A,
    input  logic [W:1]   B,
    input  logic         c0,
`ifdef ADDER_PIPE_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:1]   S,
    output logic         cout
);

    logic            adv;
    logic [W-1:0]    a_eff;
    logic [W-1:0]    b_eff;
    logic            cin0;
    logic [NSEG-1:0] valid_q;
    logic [NSEG-1:0] valid_d;
    logic [NSEG-1:0] carry;    // registered carry-out of each stage
    logic [W-1:0]    sum_w;

    // Every register in the block moves together, or none of them moves.
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_q[NSEG-1];

    // ---------------------------------------------------------------------
    // Operand conditioning. Subtraction is folded in here, before the skew
    // registers, so the per-beat sub flag needs no pipeline of its own.
    // ---------------------------------------------------------------------
`ifdef ADDER_PIPE_SUB_EN
    always_comb begin
        a_eff = A;
        b_eff = sub ? ~B : B;
        cin0  = sub | c0;
    end
`else
    always_comb begin
        a_eff = A;
        b_eff = B;
        cin0  = c0;
    end
`endif

    // ---------------------------------------------------------------------
    // Valid bits: one per stage, shifted in lockstep with the data.
    // ---------------------------------------------------------------------
    always_comb begin
        valid_d    = '0;
        valid_d[0] = in_valid;
        for (int k = 1; k < int'(NSEG); k++) begin
            valid_d[k] = valid_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (adv) begin
            valid_q <= valid_d;
        end
    end

    // ---------------------------------------------------------------------
    // Segment j (0-based) is added in stage j+1.
    // ---------------------------------------------------------------------
    for (genvar j = 0; j < int'(NSEG); j++) begin : g_seg
        // Depth and width of this segment's partial-sum delay line. Its
        // oldest entry is this segment's slice of the output register S.
        localparam int unsigned PDepth = NSEG - j;
        localparam int unsigned PW     = PDepth * SEG_W;

        logic [SEG_W-1:0] a_seg;
        logic [SEG_W-1:0] b_seg;
        logic [SEG_W-1:0] a_in;
        logic [SEG_W-1:0] b_in;
        logic             cin;
        logic [SEG_W:0]   sum;
        logic             c_q;
        logic [PW-1:0]    p_q;

        assign a_seg = a_eff[j*SEG_W +: SEG_W];
        assign b_seg = b_eff[j*SEG_W +: SEG_W];

        if (j == 0) begin : g_first
            // The lowest segment has no skew and takes the external carry-in.
            assign a_in = a_seg;
            assign b_in = b_seg;
            assign cin  = cin0;
        end else begin : g_skew
            localparam int unsigned DW = j * SEG_W;

            // The newest entry sits in the low bits and the oldest in the
            // high bits. The oldest entry reaches this stage together with
            // the carry from stage j.
            logic [DW-1:0] a_dly_q;
            logic [DW-1:0] b_dly_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_dly_q <= '0;
                    b_dly_q <= '0;
                end else if (adv) begin
                    a_dly_q <= (a_dly_q << SEG_W) | DW'(a_seg);
                    b_dly_q <= (b_dly_q << SEG_W) | DW'(b_seg);
                end
            end

            assign a_in = a_dly_q[DW-1 -: SEG_W];
            assign b_in = b_dly_q[DW-1 -: SEG_W];
            assign cin  = carry[j-1];
        end

        assign sum = {1'b0, a_in} + {1'b0, b_in} + {{SEG_W{1'b0}}, cin};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                c_q <= 1'b0;
                p_q <= '0;
            end else if (adv) begin
                c_q <= sum[SEG_W];
                p_q <= (p_q << SEG_W) | PW'(sum[SEG_W-1:0]);
            end
        end

        assign carry[j]                  = c_q;
        assign sum_w[j*SEG_W +: SEG_W]   = p_q[PW-1 -: SEG_W];
    end

    assign S    = sum_w;
    assign cout = carry[NSEG-1];

endmodule

// File: tb/tb_adder_pipe_seg.sv
module tb_adder_pipe_seg;

    localparam int W = 72;

    typedef struct {
        logic [W:1] a;
        logic [W:1] b;
        logic       c;
        logic       s;
        logic [W:0] exp;   // {cout, S}
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready1;
    logic         in_ready2;
    logic [W:1]   A;
    logic [W:1]   B;
    logic         c0;
    logic         sub;
    logic         out_valid1;
    logic         out_valid2;
    logic         out_ready;
    logic         out_ready2;
    logic [W:1]   s1;
    logic [W:1]   s2;
    logic         cout1;
    logic         cout2;

    int checks;
    int errors;

    logic [W:0] q1[$];
    logic [W:0] q2[$];
    vec_t       vecs[$];

    assign out_ready2 = 1'b1;

    adder_pipe_seg u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .A         (A),
        .B         (B),
        .c0        (c0),
`ifdef ADDER_PIPE_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .S         (s1),
        .cout      (cout1)
    );

    adder_pipe_seg #(
        .SEG_W (8),
        .NSEG  (9)
    ) u_dut9 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .A         (A),
        .B         (B),
        .c0        (c0),
`ifdef ADDER_PIPE_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .S         (s2),
        .cout      (cout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the flat W+1 bit sum the adder must produce.
    function automatic logic [W:0] model(input logic [W:1] a, input logic [W:1] b,
                                         input logic c, input logic s);
        logic [W:0] r;
        if (s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else   r = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        return r;
    endfunction

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [W:1] a, input logic [W:1] b, input logic c,
                           input logic s, input logic [W:0] exp);
        vec_t v;
        v.a = a; v.b = b; v.c = c; v.s = s; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Scoreboard: evaluated mid-cycle for the transfers at the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete();
            q2.delete();
        end else begin
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb1_unexpected: got %h expected no beat", {cout1, s1});
                end else begin
                    check("sb1_data", {cout1, s1}, q1.pop_front());
                end
            end
            if (out_valid2 && out_ready2) begin
                if (q2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb2_unexpected: got %h expected no beat", {cout2, s2});
                end else begin
                    check("sb2_data", {cout2, s2}, q2.pop_front());
                end
            end
            if (in_valid && in_ready1) q1.push_back(model(A, B, c0, sub));
            if (in_valid && in_ready2) q2.push_back(model(A, B, c0, sub));
        end
    end

    // Single beat, then exact-latency checks on both instances (3 and 9).
    task automatic one_shot(input vec_t v, input int idx);
        in_valid = 1'b1; A = v.a; B = v.b; c0 = v.c; sub = v.s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            check_bit($sformatf("vec%0d_valid3_c%0d", idx, c), out_valid1, c == 3);
            check_bit($sformatf("vec%0d_valid9_c%0d", idx, c), out_valid2, c == 9);
            if (c == 3) check($sformatf("vec%0d_sum3", idx), {cout1, s1}, v.exp);
            if (c == 9) check($sformatf("vec%0d_sum9", idx), {cout2, s2}, v.exp);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b1; in_valid = 1'b0; A = '0; B = '0; c0 = 1'b0; sub = 1'b0;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check_bit("rst_valid3", out_valid1, 1'b0);
        check_bit("rst_valid9", out_valid2, 1'b0);
        check("rst_sum3", {cout1, s1}, '0);
        check("rst_sum9", {cout2, s2}, '0);
        check_bit("rst_in_ready", in_ready1, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;

        // Directed vectors.
        add_vec('1, '0, 1'b1, 1'b0, {1'b1, 72'h0});
        add_vec(72'hFF_FFFF, 72'h1, 1'b0, 1'b0, {1'b0, 72'h100_0000});
        add_vec('0, '0, 1'b1, 1'b0, {1'b0, 72'h1});
        add_vec('1, '1, 1'b1, 1'b0, {1'b1, 72'hFF_FFFF_FFFF_FFFF_FFFF});
        add_vec(72'h80_0000_0000_0000_0000, 72'h80_0000_0000_0000_0000, 1'b0, 1'b0,
                {1'b1, 72'h0});
        add_vec(72'h12_3456_789A_BCDE_F012, 72'h0F_EDCB_A987_6543_210F, 1'b0, 1'b0,
                {1'b0, 72'h22_2222_2222_2222_1121});
`ifdef ADDER_PIPE_SUB_EN
        add_vec(72'h5, 72'h7, 1'b0, 1'b1, {1'b0, 72'hFF_FFFF_FFFF_FFFF_FFFE});
        add_vec(72'h7, 72'h5, 1'b0, 1'b1, {1'b1, 72'h2});
        add_vec(72'h7, 72'h5, 1'b1, 1'b1, {1'b1, 72'h2});
`endif
        foreach (vecs[i]) one_shot(vecs[i], i);

        // Streaming: ten back-to-back beats, outputs on ten consecutive cycles.
        for (int t = 0; t < 14; t++) begin
            if (t < 10) begin
                in_valid = 1'b1; A = W'(t); B = W'(2 * t); c0 = 1'b0; sub = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            if (t >= 3 && t < 13) begin
                check_bit($sformatf("stream_valid_t%0d", t), out_valid1, 1'b1);
                check($sformatf("stream_sum_t%0d", t), {cout1, s1}, (W+1)'(3 * (t - 3)));
            end else begin
                check_bit($sformatf("stream_idle_t%0d", t), out_valid1, 1'b0);
            end
            @(posedge clk); #1;
        end

        // Backpressure: fill, stall for four cycles, then drain.
        for (int t = 0; t < 6; t++) begin
            in_valid = 1'b1;
            A = W'({$urandom, $urandom, $urandom});
            B = W'({$urandom, $urandom, $urandom});
            c0 = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        for (int t = 0; t < 4; t++) begin
            check_bit($sformatf("stall_in_ready_t%0d", t), in_ready1, 1'b0);
            check_bit($sformatf("stall_valid_t%0d", t), out_valid1, 1'b1);
            check($sformatf("stall_hold_t%0d", t), {cout1, s1}, q1[0]);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("drain_q3_empty", (W+1)'(q1.size()), '0);

        // Randomised traffic with random stalls and bubbles.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            A  = W'({$urandom, $urandom, $urandom});
            B  = W'({$urandom, $urandom, $urandom});
            if ($urandom_range(0, 7) == 0) A = '1;
            if ($urandom_range(0, 7) == 0) B = '0;
            c0 = 1'($urandom);
`ifdef ADDER_PIPE_SUB_EN
            sub = 1'($urandom);
`endif
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("rand_q3_empty", (W+1)'(q1.size()), '0);
        check("rand_q9_empty", (W+1)'(q2.size()), '0);

        // Reset mid-flight: two beats, then reset for one cycle.
        sub = 1'b0;
        for (int t = 0; t < 2; t++) begin
            in_valid = 1'b1; A = W'(t + 100); B = W'(t + 7); c0 = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_bit("midrst_valid3", out_valid1, 1'b0);
        check_bit("midrst_valid9", out_valid2, 1'b0);
        check("midrst_sum3", {cout1, s1}, '0);
        check("midrst_sum9", {cout2, s2}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int t = 0; t < 14; t++) begin
            check_bit($sformatf("postrst_valid3_t%0d", t), out_valid1, 1'b0);
            check_bit($sformatf("postrst_valid9_t%0d", t), out_valid2, 1'b0);
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
